// File: rtl/mpu_pkg.sv
// Shared types and default geometry for the matrix-unit result path.
package mpu_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } acc_state_e;

    localparam int OUT_WIDTH = 16;
    localparam int ACC_WIDTH = 32;
    localparam int SA_ROWS   = 2;
    localparam int SA_COLS   = 2;

endpackage

// File: rtl/acc_lane.sv
// One accumulator element: sign-extend a result element and either load it or add it.
module acc_lane #(
    parameter int OUT_WIDTH = mpu_pkg::OUT_WIDTH,
    parameter int ACC_WIDTH = mpu_pkg::ACC_WIDTH
) (
    input  logic signed [OUT_WIDTH-1:0] din,
    input  logic signed [ACC_WIDTH-1:0] acc_in,
    input  logic                        overwrite,
    output logic signed [ACC_WIDTH-1:0] acc_out
);

    logic signed [ACC_WIDTH-1:0] ext;

    assign ext     = ACC_WIDTH'(din);
    // Plain two's-complement add: wraps modulo 2^ACC_WIDTH, no saturation.
    assign acc_out = overwrite ? ext : acc_in + ext;

endmodule

// File: rtl/result_accumulator.sv
// Sums k partial-result tiles from the systolic array, then drains the summed tile row by row.
module result_accumulator #(
    parameter int OUT_WIDTH = mpu_pkg::OUT_WIDTH,
    parameter int ACC_WIDTH = mpu_pkg::ACC_WIDTH,
    parameter int SA_ROWS   = mpu_pkg::SA_ROWS,
    parameter int SA_COLS   = mpu_pkg::SA_COLS
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [7:0]                   io_k_tiles,
    input  logic                         io_in_valid,
    output logic                         io_in_ready,
    input  logic [SA_COLS*OUT_WIDTH-1:0] io_in_bits_c,
    output logic                         io_out_valid,
    input  logic                         io_out_ready,
    output logic [SA_COLS*ACC_WIDTH-1:0] io_out_bits_acc,
    output logic                         io_out_bits_last
);

    import mpu_pkg::acc_state_e;
    import mpu_pkg::ACCUM;
    import mpu_pkg::DRAIN;

    localparam int RW = (SA_ROWS > 1) ? $clog2(SA_ROWS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(SA_ROWS - 1);

    acc_state_e     state_q, state_d;
    logic [RW-1:0]  row_q, row_d;
    logic [RW-1:0]  drain_q, drain_d;
    logic [7:0]     tile_q, tile_d;
    logic [7:0]     k_q, k_d;
    logic [ACC_WIDTH-1:0] acc_q [SA_ROWS][SA_COLS];
    logic [ACC_WIDTH-1:0] lane_sum [SA_COLS];

    logic       in_hs;
    logic       first_beat;
    logic [7:0] k_in_eff;
    logic [7:0] k_cur;

    assign in_hs      = io_in_valid && (state_q == ACCUM);
    assign first_beat = (tile_q == 8'd0) && (row_q == '0);
    assign k_in_eff   = (io_k_tiles == 8'd0) ? 8'd1 : io_k_tiles;
    // The group's first beat must already see the k it is about to latch.
    assign k_cur      = first_beat ? k_in_eff : k_q;

    for (genvar j = 0; j < SA_COLS; j++) begin : g_lane
        acc_lane #(
            .OUT_WIDTH(OUT_WIDTH),
            .ACC_WIDTH(ACC_WIDTH)
        ) u_lane (
            .din      (io_in_bits_c[j*OUT_WIDTH +: OUT_WIDTH]),
            .acc_in   (acc_q[row_q][j]),
            .overwrite(tile_q == 8'd0),
            .acc_out  (lane_sum[j])
        );
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        tile_d  = tile_q;
        drain_d = drain_q;
        k_d     = k_q;
        unique case (state_q)
            ACCUM: begin
                if (io_in_valid) begin
                    if (first_beat) k_d = k_in_eff;
                    if (row_q == LAST_ROW) begin
                        row_d = '0;
                        if (tile_q == k_cur - 8'd1) begin
                            tile_d  = 8'd0;
                            state_d = DRAIN;
                        end else begin
                            tile_d = tile_q + 8'd1;
                        end
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            DRAIN: begin
                if (io_out_ready) begin
                    if (drain_q == LAST_ROW) begin
                        drain_d = '0;
                        state_d = ACCUM;
                    end else begin
                        drain_d = drain_q + RW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ACCUM;
            row_q   <= '0;
            drain_q <= '0;
            tile_q  <= 8'd0;
            k_q     <= 8'd1;
            acc_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            drain_q <= drain_d;
            tile_q  <= tile_d;
            k_q     <= k_d;
            if (in_hs) begin
                for (int j = 0; j < SA_COLS; j++) acc_q[row_q][j] <= lane_sum[j];
            end
        end
    end

    // Reset gates ready so nothing is offered while the block is held in reset.
    assign io_in_ready      = (state_q == ACCUM) && !reset;
    assign io_out_valid     = (state_q == DRAIN);
    assign io_out_bits_last = (state_q == DRAIN) && (drain_q == LAST_ROW);

    always_comb begin
        io_out_bits_acc = '0;
        if (state_q == DRAIN) begin
            for (int j = 0; j < SA_COLS; j++)
                io_out_bits_acc[j*ACC_WIDTH +: ACC_WIDTH] = acc_q[drain_q][j];
        end
    end

endmodule

// File: tb/tb_result_accumulator.sv
// Directed self-checking bench for result_accumulator at default geometry (2x2, 16->32 bit).
module tb_result_accumulator;

    logic        clock;
    logic        reset;
    logic [7:0]  io_k_tiles;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [31:0] io_in_bits_c;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [63:0] io_out_bits_acc;
    logic        io_out_bits_last;

    int checks   = 0;
    int failures = 0;

    result_accumulator u_dut (
        .clock           (clock),
        .reset           (reset),
        .io_k_tiles      (io_k_tiles),
        .io_in_valid     (io_in_valid),
        .io_in_ready     (io_in_ready),
        .io_in_bits_c    (io_in_bits_c),
        .io_out_valid    (io_out_valid),
        .io_out_ready    (io_out_ready),
        .io_out_bits_acc (io_out_bits_acc),
        .io_out_bits_last(io_out_bits_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One accepted beat: drive at a falling edge, the rising edge takes it.
    task automatic send_row(input int e0, input int e1);
        io_in_valid  = 1'b1;
        io_in_bits_c = {16'(e1), 16'(e0)};
        @(negedge clock);
        io_in_valid  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!io_out_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(io_out_valid), 32'd1);
    endtask

    task automatic expect_drain(input string tag, input int e0, input int e1, input logic last);
        check({tag, "_valid"}, 32'(io_out_valid), 32'd1);
        check({tag, "_ready"}, 32'(io_in_ready), 32'd0);
        check({tag, "_e0"}, io_out_bits_acc[31:0], 32'(e0));
        check({tag, "_e1"}, io_out_bits_acc[63:32], 32'(e1));
        check({tag, "_last"}, 32'(io_out_bits_last), 32'(last));
        io_out_ready = 1'b1;
        @(negedge clock);
        io_out_ready = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        io_k_tiles   = 8'd1;
        io_in_valid  = 1'b0;
        io_in_bits_c = '0;
        io_out_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_ready", 32'(io_in_ready), 32'd0);
        check("rst_valid", 32'(io_out_valid), 32'd0);
        check("rst_last", 32'(io_out_bits_last), 32'd0);
        check("rst_acc", io_out_bits_acc[31:0] | io_out_bits_acc[63:32], 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_ready", 32'(io_in_ready), 32'd1);

        // k=1 basic group and 1-cycle latency
        io_k_tiles = 8'd1;
        send_row(3, -2);
        check("k1_valid_mid", 32'(io_out_valid), 32'd0);
        send_row(-8, 7);
        check("k1_latency", 32'(io_out_valid), 32'd1);
        expect_drain("k1_r0", 3, -2, 1'b0);
        expect_drain("k1_r1", -8, 7, 1'b1);
        check("k1_back_ready", 32'(io_in_ready), 32'd1);
        check("k1_back_valid", 32'(io_out_valid), 32'd0);

        // k=3 sums six identical beats
        io_k_tiles = 8'd3;
        repeat (6) send_row(1, -1);
        wait_valid("k3_wait");
        expect_drain("k3_r0", 3, -3, 1'b0);
        expect_drain("k3_r1", 3, -3, 1'b1);

        // k=2 with max positive elements: no saturation
        io_k_tiles = 8'd2;
        repeat (4) send_row(32'h7FFF, 32'h7FFF);
        wait_valid("k2_wait");
        expect_drain("k2sat_r0", 32'h0000FFFE, 32'h0000FFFE, 1'b0);
        expect_drain("k2sat_r1", 32'h0000FFFE, 32'h0000FFFE, 1'b1);

        // Backpressure in drain with ignored input pulses
        io_k_tiles = 8'd1;
        send_row(5, 6);
        send_row(7, 8);
        for (int i = 0; i < 5; i++) begin
            io_in_valid  = i[0];
            io_in_bits_c = {16'd100, 16'd200};
            @(negedge clock);
            check("bp_valid", 32'(io_out_valid), 32'd1);
            check("bp_e0", io_out_bits_acc[31:0], 32'd5);
            check("bp_last", 32'(io_out_bits_last), 32'd0);
        end
        io_in_valid = 1'b0;
        expect_drain("bp_r0", 5, 6, 1'b0);
        expect_drain("bp_r1", 7, 8, 1'b1);

        // Reset after 3 of 4 beats, then a fresh k=1 group
        io_k_tiles = 8'd2;
        repeat (3) send_row(1, 1);
        #2 reset = 1'b1;
        #1;
        check("mrst_ready", 32'(io_in_ready), 32'd0);
        check("mrst_valid", 32'(io_out_valid), 32'd0);
        check("mrst_acc", io_out_bits_acc[31:0] | io_out_bits_acc[63:32], 32'd0);
        @(negedge clock);
        reset = 1'b0;
        io_k_tiles = 8'd1;
        send_row(9, -9);
        check("mrst_no_early", 32'(io_out_valid), 32'd0);
        send_row(10, -10);
        check("mrst_latency", 32'(io_out_valid), 32'd1);
        expect_drain("mrst_r0", 9, -9, 1'b0);
        expect_drain("mrst_r1", 10, -10, 1'b1);

        // k=0 behaves as k=1
        io_k_tiles = 8'd0;
        send_row(2, 3);
        send_row(4, 5);
        check("k0_latency", 32'(io_out_valid), 32'd1);
        expect_drain("k0_r0", 2, 3, 1'b0);
        expect_drain("k0_r1", 4, 5, 1'b1);

        // k changed mid-group is not picked up
        io_k_tiles = 8'd2;
        send_row(1, 2);
        io_k_tiles = 8'd1;
        send_row(3, 4);
        check("kchg_no_drain", 32'(io_out_valid), 32'd0);
        send_row(10, 20);
        send_row(30, 40);
        check("kchg_latency", 32'(io_out_valid), 32'd1);
        expect_drain("kchg_r0", 11, 22, 1'b0);
        expect_drain("kchg_r1", 33, 44, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_accumulator.md
RESULT_ACCUMULATOR -- requirements
Module: result_accumulator

Interface
REQ-001 Parameter OUT_WIDTH, default 16, SHALL set the width of each systolic-array result element received.
REQ-002 Parameter ACC_WIDTH, default 32, SHALL set the width of each accumulator element; ACC_WIDTH >= OUT_WIDTH.
REQ-003 Parameter SA_ROWS, default 2, SHALL set the number of result rows per tile.
REQ-004 Parameter SA_COLS, default 2, SHALL set the number of elements per result row (beat).
REQ-005 Port clock, input, 1, SHALL be the single clock; all state is updated on its rising edge.
REQ-006 Port reset, input, 1, SHALL be an asynchronous, active-high reset.
REQ-007 Port io_k_tiles, input, 8, SHALL give the number of partial-result tiles to sum per output tile.
REQ-008 Port io_in_valid, input, 1, SHALL mark a valid result row from the array.
REQ-009 Port io_in_ready, output, 1, SHALL indicate that a result row can be accepted.
REQ-010 Port io_in_bits_c, input, SA_COLS x OUT_WIDTH signed, SHALL carry one result row, elements 0..SA_COLS-1.
REQ-011 Port io_out_valid, output, 1, SHALL mark a valid accumulated row.
REQ-012 Port io_out_ready, input, 1, SHALL be the downstream acceptance of the accumulated row.
REQ-013 Port io_out_bits_acc, output, SA_COLS x ACC_WIDTH signed, SHALL carry one accumulated row.
REQ-014 Port io_out_bits_last, output, 1, SHALL be high on the final row of the output tile.

Function
REQ-015 The FSM SHALL have exactly two states, ACCUM and DRAIN; reset state ACCUM.
REQ-016 In ACCUM, io_in_ready SHALL be 1 and io_out_valid SHALL be 0; in DRAIN, io_in_ready SHALL be 0 and io_out_valid SHALL be 1.
REQ-017 An input handshake (io_in_valid && io_in_ready) SHALL update acc[row_cnt][j] for every j and then advance row_cnt, wrapping SA_ROWS-1 -> 0.
REQ-018 When tile_cnt == 0, the update SHALL overwrite with sign-extended io_in_bits_c[j]; otherwise it SHALL add sign-extended io_in_bits_c[j] to acc, wrapping modulo 2^ACC_WIDTH.
REQ-019 io_k_tiles SHALL be latched into k_reg on the handshake with tile_cnt == 0 and row_cnt == 0; the value 0 SHALL be treated as 1.
REQ-020 When row_cnt wraps, tile_cnt SHALL increment; when row_cnt wraps with tile_cnt == k_reg-1, tile_cnt SHALL clear and the FSM SHALL enter DRAIN on the next edge.
REQ-021 io_out_valid SHALL rise in the first cycle after the final input handshake of a group (latency 1 cycle).
REQ-022 In DRAIN, io_out_bits_acc SHALL present acc[drain_cnt]; an output handshake SHALL advance drain_cnt; io_out_bits_last SHALL equal (drain_cnt == SA_ROWS-1).
REQ-023 The output handshake with last high SHALL clear drain_cnt and return the FSM to ACCUM; io_in_ready SHALL be 1 in the following cycle.
REQ-024 While io_out_ready is low in DRAIN, io_out_bits_acc and io_out_bits_last SHALL remain stable.
REQ-025 io_in_valid asserted during DRAIN SHALL be ignored, with no state change.
REQ-026 Outputs SHALL be driven from registered state only, with no combinational path from io_out_ready to io_in_ready.

Reset
REQ-027 Asserting reset at any time, including mid-group or mid-drain, SHALL immediately force state ACCUM, row_cnt = tile_cnt = drain_cnt = 0, k_reg = 1, and all acc = 0.
REQ-028 During reset, io_in_ready, io_out_valid and io_out_bits_last SHALL be 0 and io_out_bits_acc SHALL be 0.

Structure
REQ-029 A shared package mpu_pkg SHALL hold the state enum (ACCUM, DRAIN) and the default width constants OUT_WIDTH, ACC_WIDTH, SA_ROWS and SA_COLS.
REQ-030 The per-element sign-extend-and-add SHALL be one sub-module, acc_lane, instantiated SA_COLS times; no other hierarchy.

Verification
REQ-031 k=1, rows {3,-2},{-8,7} -> out {3,-2} last=0, then {-8,7} last=1; io_out_valid first high 1 cycle after the 2nd input beat.
REQ-032 k=3, same row {1,-1} in all 6 beats -> both output rows {3,-3}; io_in_ready low for the entire drain.
REQ-033 k=2, OUT=16'sh7FFF twice per element -> acc 32'sh0000FFFE, with no saturation.
REQ-034 io_out_ready held low 5 cycles in DRAIN -> valid stays high and data stays constant; io_in_valid pulses during this window are ignored.
REQ-035 reset asserted after 3 of 4 beats (k=2) -> outputs 0 immediately; a fresh k=1 group afterwards produces only the new values.
REQ-036 io_k_tiles=0 -> behaves as k=1; io_k_tiles changed mid-group -> k_reg is unchanged until the next group.
